// File: rtl/interrupt_priority_arbiter.sv
// Fixed-priority interrupt arbiter: edge-latches sources as pending, grants one at a
// time (lowest index first) with a one-cycle request pulse and tracks it until ISR return.
module interrupt_priority_arbiter #(
  parameter int unsigned NUM_SRC       = 8,
  parameter int unsigned ID_W          = 3,
  parameter int unsigned VECTOR_BASE   = 20,
  parameter int unsigned VECTOR_STRIDE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               stall,
  input  logic               isr_return,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        irq_vector,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [31:0]        irq_vector_q, irq_vector_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    winner;
  logic               grant;

  assign rise     = irq_in & ~irq_q;
  assign eligible = pending_q & irq_mask;

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  assign grant = (state_q == IDLE) && (eligible != '0) && !stall;

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    irq_vector_d = irq_vector_q;
    pending_d    = pending_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d             = REQ;
          irq_id_d            = winner;
          irq_vector_d        = 32'(VECTOR_BASE) + 32'(winner) * 32'(VECTOR_STRIDE);
          pending_d[winner]   = 1'b0;
        end
      end
      REQ:     state_d = SERVICE;
      SERVICE: begin
        if (isr_return) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A fresh edge on the bit being granted wins over the clear.
    pending_d = pending_d | rise;
  end

  // irq_q follows irq_in even in reset so a line held high across reset is not an edge.
  always_ff @(posedge clk) begin
    irq_q <= irq_in;
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      irq_id_q     <= '0;
      irq_vector_q <= 32'(VECTOR_BASE);
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      irq_id_q     <= irq_id_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign irq_id     = irq_id_q;
  assign irq_vector = irq_vector_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Self-checking bench for interrupt_priority_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_interrupt_priority_arbiter;

  localparam int NSRC = 8;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic [NSRC-1:0] irq_mask;
  logic            stall;
  logic            isr_return;
  logic            irq_req;
  logic [2:0]      irq_id;
  logic [31:0]     irq_vector;
  logic            busy;
  logic [NSRC-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference model: which phase of a service we are in, counted as plain integers.
  int unsigned m_prev_in;
  int unsigned m_pend;
  int          m_phase;
  int unsigned m_id;
  int unsigned m_vec;

  interrupt_priority_arbiter #(
    .NUM_SRC(8), .ID_W(3), .VECTOR_BASE(20), .VECTOR_STRIDE(16)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_mask(irq_mask), .stall(stall),
    .isr_return(isr_return), .irq_req(irq_req), .irq_id(irq_id),
    .irq_vector(irq_vector), .busy(busy), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    int unsigned rise;
    int unsigned elig;
    if (reset) begin
      m_phase = 0;
      m_pend  = 0;
      m_id    = 0;
      m_vec   = 20;
    end else begin
      rise = irq_in & ~m_prev_in & 32'hFF;
      elig = m_pend & irq_mask;
      if (m_phase == 0 && elig != 0 && !stall) begin
        for (int i = 0; i < NSRC; i++) begin
          if (elig[i]) begin
            m_id   = i;
            m_vec  = 20 + 16 * i;
            m_pend = m_pend & ~(32'd1 << i);
            break;
          end
        end
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && isr_return) begin
        m_phase = 3;
      end else if (m_phase == 3) begin
        m_phase = 0;
      end
      m_pend = m_pend | rise;
    end
    m_prev_in = irq_in;
  endtask

  task automatic checkOutput();
    checkVal("irq_req", 32'(irq_req), 32'(m_phase == 1));
    checkVal("busy", 32'(busy), 32'(m_phase != 0));
    checkVal("pending", 32'(pending), m_pend);
    checkVal("irq_id", 32'(irq_id), m_id);
    checkVal("irq_vector", irq_vector, m_vec);
  endtask

  task automatic step();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [7:0] irq, input logic [7:0] mask,
                               input logic stl, input logic ret, input logic rst);
    irq_in     = irq;
    irq_mask   = mask;
    stall      = stl;
    isr_return = ret;
    reset      = rst;
  endtask

  initial begin
    m_prev_in = 0; m_pend = 0; m_phase = 0; m_id = 0; m_vec = 20;
    applyStimulus(8'h10, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(); step();
    checkVal("reset_busy", 32'(busy), 32'd0);
    checkVal("reset_vector", irq_vector, 32'd20);
    applyStimulus(8'h10, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(); step();
    checkVal("held_line_no_pending", 32'(pending), 32'd0);

    // Single source
    applyStimulus(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("single_pending", 32'(pending), 32'h08);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("single_req", 32'(irq_req), 32'd1);
    checkVal("single_id", 32'(irq_id), 32'd3);
    checkVal("single_vec", irq_vector, 32'd68);
    checkVal("single_pend_clr", 32'(pending), 32'd0);
    step(); step();
    checkVal("single_req_once", 32'(irq_req), 32'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    checkVal("single_drain_busy", 32'(busy), 32'd1);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("single_idle_busy", 32'(busy), 32'd0);

    // Priority
    applyStimulus(8'h24, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("prio_first_id", 32'(irq_id), 32'd2);
    checkVal("prio_first_vec", irq_vector, 32'd52);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("prio_gap_busy", 32'(busy), 32'd0);
    step();
    checkVal("prio_second_req", 32'(irq_req), 32'd1);
    checkVal("prio_second_id", 32'(irq_id), 32'd5);
    checkVal("prio_second_vec", irq_vector, 32'd100);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();

    // Mask and stall
    applyStimulus(8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFE, 1'b0, 1'b0, 1'b0);
    step(); step();
    checkVal("masked_pending", 32'(pending), 32'h01);
    checkVal("masked_no_req", 32'(busy), 32'd0);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkVal("stall_no_req", 32'(irq_req), 32'd0);
    end
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("unstall_req", 32'(irq_req), 32'd1);
    checkVal("unstall_vec", irq_vector, 32'd20);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();

    // Re-trigger of the in-service source
    applyStimulus(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(); step();
    applyStimulus(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    checkVal("retrig_pending", 32'(pending), 32'h02);
    checkVal("retrig_no_preempt", 32'(irq_req), 32'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(); step();
    checkVal("retrig_second_id", 32'(irq_id), 32'd1);
    checkVal("retrig_second_req", 32'(irq_req), 32'd1);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();

    // Reset during service
    applyStimulus(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(); step();
    applyStimulus(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step();
    checkVal("midreset_busy", 32'(busy), 32'd0);
    checkVal("midreset_pending", 32'(pending), 32'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();

    // Spurious return in IDLE
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    checkVal("spurious_busy", 32'(busy), 32'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(8'($urandom) & 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 96) == 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_priority_arbiter.md
Name: interrupt_priority_arbiter

Overview:
- Collects up to NUM_SRC external interrupt sources, latches them as pending, and picks one by fixed priority.
- Issues a single one-cycle interrupt request to the pipeline's PC-redirect / interrupt control unit and tracks the in-service source until the ISR returns.
- Sits between peripheral IRQ lines (neuron-core event flags, timers) and the core's interrupt input. Enforces one interrupt at a time, with no nesting.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..16).
- ID_W, 3, width of the source id; must equal ceil(log2(NUM_SRC)).
- VECTOR_BASE, 20, byte address of handler slot 0.
- VECTOR_STRIDE, 16, byte spacing between handler slots.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- irq_in  in  NUM_SRC  raw source lines, already synchronous to clk; edge-triggered.
- irq_mask  in  NUM_SRC  1 = source enabled for grant; static config from CSR.
- stall  in  1  pipeline stall; no new request is issued while high.
- isr_return  in  1  one-cycle pulse: core executed the ISR return (jalr through x30).
- irq_req  out  1  one-cycle request pulse to the interrupt control unit.
- irq_id  out  ID_W  id of the granted / in-service source.
- irq_vector  out  32  VECTOR_BASE + irq_id*VECTOR_STRIDE.
- busy  out  1  high from grant until return completes.
- pending  out  NUM_SRC  current pending bits.

Behaviour:
- Reset (synchronous): state=IDLE, pending=0, irq_req=0, busy=0, irq_id=0, irq_vector=VECTOR_BASE, irq_q<=irq_in.
  - Loading irq_q from irq_in means a line held high through reset does not generate an edge.
- Edge detect: irq_q<=irq_in every cycle. rise[i]=irq_in[i]&~irq_q[i] sets pending[i] at that edge.
- Masking: masked sources still latch pending; they are only excluded from selection.
  - Unmasking later makes them eligible on the next cycle.
- Selection: eligible = pending & irq_mask. The lowest index wins (bit 0 is highest priority). Purely combinational from registered pending.
- FSM states IDLE, REQ, SERVICE, DRAIN:
  - IDLE: if eligible!=0 and stall=0 then go to REQ. At the same edge, latch irq_id=winner, clear pending[winner], update irq_vector.
  - IDLE with stall=1: hold, no request.
  - REQ: irq_req=1 for exactly this one cycle, busy=1; go to SERVICE unconditionally.
  - SERVICE: busy=1, irq_req=0; on isr_return=1 go to DRAIN.
  - DRAIN: busy=1 for one cycle to let the return jump retire; go to IDLE.
- Latency: an edge sampled at posedge t gives pending at t. The earliest grant edge is t+1, and irq_req is high during the cycle following t+1.
- irq_req is held a full clock period so a negedge-clocked consumer samples it exactly once.
- Back-to-back: with another source pending, the earliest next irq_req comes 1 cycle after DRAIN (IDLE→REQ at the edge leaving IDLE).
- Simultaneous set and clear on the same bit at the grant edge: set wins, pending stays 1 and is serviced again later.
- isr_return in IDLE or REQ: ignored. A new edge on the in-service source during SERVICE: pending set, no preemption.
- irq_id and irq_vector hold their last granted value outside service. Vector arithmetic is 32-bit unsigned with wrap-around.
- Reset mid-service: immediately returns to IDLE, pending cleared, no irq_req issued in the reset cycle.

Test Plan:
- Single source: mask=8'hFF, pulse irq_in[3] → pending=8'h08 next cycle; irq_req one cycle later with irq_id=3, irq_vector=68; pending=0, busy=1 until isr_return + 1 cycle.
- Priority: raise irq_in[5] and irq_in[2] in the same cycle → first grant id=2 (vector 52). After isr_return and DRAIN, the second grant is id=5 (vector 100) exactly 1 cycle after busy falls.
- Mask and stall: mask=8'hFE, pulse irq_in[0] → pending[0]=1, no irq_req. Set mask=8'hFF with stall=1 for 4 cycles → no request; release stall → irq_req with id=0, vector 20.
- Re-trigger: during SERVICE of id=1, pulse irq_in[1] again → no preemption, pending[1]=1; after return, a second grant with id=1.
- Reset: hold irq_in[4]=1 across reset → no pending after release. Assert reset during SERVICE → busy=0, pending=0, state IDLE next cycle.
- Spurious return: isr_return pulse in IDLE → no state change, busy stays 0.
